traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
//  N-approach successor of the two-road highway/country controller. Sensor inputs are
//  synchronised internally and latched as pending demand; one approach is green at a time.
//  Per-phase min/max green, yellow and all-red clearance times are programmable.
//  Approach 0 is the home/priority road; other approaches are served round-robin on demand.
//  Sits between the raw sensor pins and the lamp drivers; replaces sync+timer+next-state+decoder.
// PARAMETERS
//  NUM_DIR   2   number of approaches (2..8); approach 0 = home/priority road
//  TIME_W    4   width of each time input, in ticks
//  TICK_DIV  1   clocks per timer tick (1 = every clock); prescaler cleared on each state entry
// PORTS
//  clock       in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-high; clears all state
//  car_async   in   NUM_DIR      raw per-approach sensor, asynchronous to clock
//  time_min    in   TIME_W       minimum green time, ticks
//  time_max    in   TIME_W       maximum green time for non-home approaches, ticks
//  time_yellow in   TIME_W       yellow time, ticks
//  time_allred in   TIME_W       all-red clearance time, ticks
//  green       out  NUM_DIR      per-approach green lamp
//  yellow      out  NUM_DIR      per-approach yellow lamp
//  red         out  NUM_DIR      per-approach red lamp
//  cur_dir     out  clog2(NUM_DIR)  approach currently owning the phase
//  phase       out  2            00 GREEN, 01 YELLOW, 10 ALLRED (11 unused)
// BEHAVIOUR
//  - Reset (async): phase=GREEN, cur_dir=0, timer/prescaler=0, pend=0, sync flops=0.
//    Outputs during/after reset: green[0]=1, red[i]=1 for i!=0, all yellow=0.
//  - Lamps are registered-state decoded: each approach has exactly one of g/y/r high.
//    Only cur_dir shows green/yellow; in ALLRED every approach is red.
//  - Sync: 2-flop synchroniser per bit -> car_sync. pend[i] is set the cycle after
//    car_sync[i]=1 (3 clocks after async edge). It is cleared when approach i enters GREEN.
//    If set and clear coincide, clear wins. Demand from cur_dir while it is GREEN is not
//    latched, but car_sync[cur_dir] is seen directly.
//  - Time values are sampled into a shadow register on state entry. Mid-phase changes
//    apply from the next state. A value of 0 is treated as 1. State duration = value*TICK_DIV clocks.
//  - elapsed counts ticks since state entry and saturates at 2^TIME_W-1.
//  - GREEN, cur_dir==0: leave to YELLOW when elapsed>=time_min and any pend[i!=0].
//    Otherwise hold indefinitely; time_max is ignored.
//  - GREEN, cur_dir!=0: leave when elapsed>=time_max, or when elapsed>=time_min and
//    car_sync[cur_dir]==0.
//  - YELLOW -> ALLRED after time_yellow. ALLRED -> GREEN after time_allred.
//  - Next approach is chosen in the last ALLRED cycle: the first pending i scanning
//    cur_dir+1, cur_dir+2, ... modulo NUM_DIR, excluding cur_dir. If none is pending, next is 0.
//  - A state transition resets elapsed and the prescaler to 0 in the same clock.
//  - Reset asserted mid-phase: outputs return to reset values immediately (async).
//    All pending demand is lost.
// STRUCTURE
//  - Shared package traffic_pkg holds:
//    - phase encodings PH_GREEN/PH_YELLOW/PH_ALLRED;
//    - the clog2 helper for cur_dir width;
//    - the lamp-triplet ordering constants.
//  - Sub-module traffic_phase_timer: prescaler, shadow time register, saturating elapsed
//    counter and a "done" compare. Inputs are the load strobe and the selected time.
//  - Top level contains the synchroniser, pend latches, FSM, round-robin pick and lamp decode.
// TESTING (NUM_DIR=2, TICK_DIV=1, min=4 max=8 yellow=2 allred=1 unless stated)
//  1 Reset, car_async=0 for 100 clk -> green=01, red=10 throughout; phase=00, cur_dir=0.
//  2 car_async[1] 1-clk pulse at clk 10 -> pend[1] set clk 13; yellow[0] clk 14-15;
//    allred clk 16; green[1] clk 17-20; then yellow[1] 2 clk, allred 1 clk, green[0].
//  3 car_async[1] held high -> green[1] lasts exactly 8 clk, then returns to approach 0.
//  4 NUM_DIR=4, pend[3] and pend[2] raised while cur_dir=0 -> served 2, then 3, then 0.
//  5 reset pulse during YELLOW of approach 0 -> green[0]=1 same cycle as reset; pend=0.
//  6 time_yellow=0, time_allred=0 -> each lasts 1 clk. TICK_DIV=3 -> yellow=2 ticks lasts 6 clk.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-approach traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_t;

  localparam int unsigned LAMP_G = 0;
  localparam int unsigned LAMP_Y = 1;
  localparam int unsigned LAMP_R = 2;

  function automatic int unsigned dir_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Exactly one lamp of the triplet is lit; only the phase owner leaves red.
  function automatic logic [2:0] lamp_triplet(input phase_t ph, input logic owner);
    logic [2:0] t;
    t = '0;
    if (owner && ph == PH_GREEN)       t[LAMP_G] = 1'b1;
    else if (owner && ph == PH_YELLOW) t[LAMP_Y] = 1'b1;
    else                               t[LAMP_R] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase timer: tick prescaler, shadowed time values and saturating elapsed-tick counter.
module traffic_phase_timer #(
  parameter int unsigned TIME_W   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_sample,
  input  logic [TIME_W-1:0] i_time_a,
  input  logic [TIME_W-1:0] i_time_b,
  output logic              o_done_a,
  output logic              o_done_b
);

  localparam int unsigned       PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] SAT      = '1;

  logic [PW-1:0]     r_pre;
  logic [TIME_W-1:0] r_elapsed;
  logic [TIME_W-1:0] r_time_a;
  logic [TIME_W-1:0] r_time_b;
  logic              w_tick;
  logic [TIME_W-1:0] w_elapsed_nx;
  logic [TIME_W-1:0] w_lim_a;
  logic [TIME_W-1:0] w_lim_b;

  // Done compares include the tick landing this cycle, so a value of N lasts N ticks.
  always_comb begin
    w_tick       = (r_pre == PRE_LAST);
    w_elapsed_nx = (w_tick && r_elapsed != SAT) ? r_elapsed + 1'b1 : r_elapsed;
    w_lim_a      = (r_time_a == '0) ? TIME_W'(1) : r_time_a;
    w_lim_b      = (r_time_b == '0) ? TIME_W'(1) : r_time_b;
    o_done_a     = (w_elapsed_nx >= w_lim_a);
    o_done_b     = (w_elapsed_nx >= w_lim_b);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre     <= '0;
      r_elapsed <= '0;
      r_time_a  <= '0;
      r_time_b  <= '0;
    end else begin
      if (i_load || i_sample) begin
        r_time_a <= i_time_a;
        r_time_b <= i_time_b;
      end
      if (i_load) begin
        r_pre     <= '0;
        r_elapsed <= '0;
      end else begin
        r_pre     <= w_tick ? '0 : r_pre + 1'b1;
        r_elapsed <= w_elapsed_nx;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach traffic phase controller: sensor sync, demand latches, phase FSM,
// round-robin approach selection and registered lamp decode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned TIME_W   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_DIR-1:0]          car_async,
  input  logic [TIME_W-1:0]           time_min,
  input  logic [TIME_W-1:0]           time_max,
  input  logic [TIME_W-1:0]           time_yellow,
  input  logic [TIME_W-1:0]           time_allred,
  output logic [NUM_DIR-1:0]          green,
  output logic [NUM_DIR-1:0]          yellow,
  output logic [NUM_DIR-1:0]          red,
  output logic [dir_w(NUM_DIR)-1:0]   cur_dir,
  output logic [1:0]                  phase
);

  localparam int unsigned DW = dir_w(NUM_DIR);
  typedef logic [DW-1:0] dir_t;

  logic [NUM_DIR-1:0] r_sync1;
  logic [NUM_DIR-1:0] r_sync2;
  logic [NUM_DIR-1:0] r_pend;
  phase_t             r_state;
  dir_t               r_dir;
  logic               r_init;

  phase_t             w_state_nx;
  dir_t               w_dir_nx;
  dir_t               w_pick;
  logic               w_found;
  logic               w_leave;
  logic               w_others;
  logic               w_done_a;
  logic               w_done_b;
  logic [TIME_W-1:0]  w_time_a;
  logic [NUM_DIR-1:0] w_pend_nx;
  logic [NUM_DIR-1:0] w_lamp_g;
  logic [NUM_DIR-1:0] w_lamp_y;
  logic [NUM_DIR-1:0] w_lamp_r;
  logic [2:0]         w_tri;

  // r_init re-samples the time inputs on the first clock after reset.
  traffic_phase_timer #(
    .TIME_W   (TIME_W),
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_leave),
    .i_sample (r_init),
    .i_time_a (w_time_a),
    .i_time_b (time_max),
    .o_done_a (w_done_a),
    .o_done_b (w_done_b)
  );

  always_comb begin : pick
    int unsigned idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k < NUM_DIR; k++) begin
      idx = (32'(r_dir) + k) % NUM_DIR;
      if (!w_found && r_pend[dir_t'(idx)]) begin
        w_found = 1'b1;
        w_pick  = dir_t'(idx);
      end
    end
  end

  always_comb begin
    w_others   = |r_pend[NUM_DIR-1:1];
    w_leave    = 1'b0;
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    case (r_state)
      PH_GREEN: begin
        if (r_dir == '0) w_leave = w_done_a && w_others;
        else             w_leave = w_done_b || (w_done_a && !r_sync2[r_dir]);
      end
      PH_YELLOW: w_leave = w_done_a;
      PH_ALLRED: w_leave = w_done_a;
      default:   w_leave = 1'b1;
    endcase
    if (w_leave) begin
      case (r_state)
        PH_GREEN:  w_state_nx = PH_YELLOW;
        PH_YELLOW: w_state_nx = PH_ALLRED;
        PH_ALLRED: begin
          w_state_nx = PH_GREEN;
          w_dir_nx   = w_found ? w_pick : '0;
        end
        default: begin
          w_state_nx = PH_GREEN;
          w_dir_nx   = '0;
        end
      endcase
    end
    case (w_state_nx)
      PH_GREEN:  w_time_a = time_min;
      PH_YELLOW: w_time_a = time_yellow;
      default:   w_time_a = time_allred;
    endcase
  end

  // Clear on green entry wins over a same-cycle set.
  always_comb begin
    w_pend_nx = r_pend;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      w_pend_nx[i] = (r_pend[i] | (r_sync2[i] & !(r_state == PH_GREEN && r_dir == dir_t'(i))))
                   & !(w_leave && r_state == PH_ALLRED && w_dir_nx == dir_t'(i));
    end
  end

  always_comb begin
    w_lamp_g = '0;
    w_lamp_y = '0;
    w_lamp_r = '0;
    w_tri    = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      w_tri       = lamp_triplet(w_state_nx, w_dir_nx == dir_t'(i));
      w_lamp_g[i] = w_tri[LAMP_G];
      w_lamp_y[i] = w_tri[LAMP_Y];
      w_lamp_r[i] = w_tri[LAMP_R];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pend  <= '0;
      r_state <= PH_GREEN;
      r_dir   <= '0;
      r_init  <= 1'b1;
      green   <= NUM_DIR'(1);
      yellow  <= '0;
      red     <= ~NUM_DIR'(1);
    end else begin
      r_sync1 <= car_async;
      r_sync2 <= r_sync1;
      r_pend  <= w_pend_nx;
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_init  <= 1'b0;
      green   <= w_lamp_g;
      yellow  <= w_lamp_y;
      red     <= w_lamp_r;
    end
  end

  assign cur_dir = r_dir;
  assign phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller (4 approaches, 2 clocks per tick) against a tick-count model.
module tb_traffic_phase_controller;

  localparam int ND = 4;
  localparam int TD = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [ND-1:0] car = '0;
  logic [3:0]    tmin = 4'd4, tmax = 4'd8, tyel = 4'd2, tar = 4'd1;
  logic [ND-1:0] green, yellow, red;
  logic [1:0]    cur_dir, phase;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // model: phase 0/1/2 = green/yellow/allred, m_k = clocks spent in the current phase
  int       m_ph, m_dir, m_k;
  bit [3:0] m_s1, m_s2, m_pend;
  int       m_sh [4];
  bit       m_init;

  traffic_phase_controller #(.NUM_DIR(ND), .TIME_W(4), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .car_async(car),
    .time_min(tmin), .time_max(tmax), .time_yellow(tyel), .time_allred(tar),
    .green(green), .yellow(yellow), .red(red), .cur_dir(cur_dir), .phase(phase)
  );

  always #5 clock = ~clock;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_dir = 0; m_k = 0; m_s1 = '0; m_s2 = '0; m_pend = '0;
      m_sh = '{0, 0, 0, 0}; m_init = 1;
    end else begin
      int ticks;
      bit leave;
      int nd;
      bit [3:0] np;
      ticks = (m_k + 1) / TD;
      if (ticks > 15) ticks = 15;
      if (m_ph == 0)
        leave = (m_dir == 0) ? (ticks >= eff(m_sh[0]) && (m_pend >> 1) != 0)
                             : (ticks >= eff(m_sh[1]) || (ticks >= eff(m_sh[0]) && !m_s2[m_dir]));
      else if (m_ph == 1) leave = ticks >= eff(m_sh[2]);
      else                leave = ticks >= eff(m_sh[3]);
      nd = m_dir;
      if (leave && m_ph == 2) begin
        nd = 0;
        for (int j = 1; j < ND; j++)
          if (m_pend[(m_dir + j) % ND]) begin nd = (m_dir + j) % ND; break; end
      end
      np = m_pend;
      for (int i = 0; i < ND; i++) begin
        if (m_s2[i] && !(m_ph == 0 && m_dir == i)) np[i] = 1'b1;
        if (leave && m_ph == 2 && nd == i) np[i] = 1'b0;
      end
      if (leave || m_init) m_sh = '{int'(tmin), int'(tmax), int'(tyel), int'(tar)};
      m_init = 0;
      m_pend = np;
      m_s2 = m_s1;
      m_s1 = car;
      if (leave) begin m_ph = (m_ph + 1) % 3; m_dir = nd; m_k = 0; end
      else if (m_k < 1000) m_k++;
    end
  end

  always @(negedge clock) begin
    logic [ND-1:0] eg, ey, er;
    if (cmp_en) begin
      eg = '0; ey = '0; er = '0;
      for (int i = 0; i < ND; i++) begin
        if (m_ph == 0 && m_dir == i)      eg[i] = 1'b1;
        else if (m_ph == 1 && m_dir == i) ey[i] = 1'b1;
        else                              er[i] = 1'b1;
      end
      checks++;
      if ({green, yellow, red} !== {eg, ey, er} || cur_dir !== 2'(m_dir) || phase !== 2'(m_ph)) begin
        errors++;
        $display("FAIL outputs t=%0t got g=%b y=%b r=%b dir=%0d ph=%0d want g=%b y=%b r=%b dir=%0d ph=%0d",
                 $time, green, yellow, red, cur_dir, phase, eg, ey, er, m_dir, m_ph);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int ph, input int dir, input string name, output int n);
    n = 0;
    while (!(phase == 2'(ph) && cur_dir == 2'(dir)) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting ph=%0d dir=%0d", name, ph, dir);
    end
  endtask

  task automatic wait_new_green(input int from, input string name, output int d);
    int n;
    n = 0;
    while (!(phase == 2'd0 && cur_dir != 2'(from)) && n < 300) begin
      @(negedge clock);
      n++;
    end
    d = int'(cur_dir);
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s timeout leaving dir %0d", name, from);
    end
  endtask

  task automatic measure(output int n);
    logic [1:0] p0, d0;
    bit same;
    p0 = phase; d0 = cur_dir; n = 1;
    do begin
      @(negedge clock);
      same = (phase == p0 && cur_dir == d0);
      if (same) n++;
    end while (same && n < 300);
  endtask

  task automatic pulse(input logic [ND-1:0] bits);
    car = bits;
    @(negedge clock);
    car = '0;
  endtask

  initial begin
    int n, d;
    #1 reset = 1'b1;
    cmp_en = 1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    repeat (30) @(negedge clock);
    check("idle_green", int'(green), 1);
    check("idle_red", int'(red), 14);
    check("idle_phase", int'(phase), 0);
    check("idle_dir", int'(cur_dir), 0);

    pulse(4'b0010);
    wait_state(1, 0, "demand_latency", n);
    check("demand_latency", n, 3);
    measure(n); check("yellow0_len", n, 4);
    check("allred_phase", int'(phase), 2);
    measure(n); check("allred_len", n, 2);
    check("served_dir1", int'(cur_dir), 1);
    measure(n); check("green1_min_len", n, 8);
    measure(n); check("yellow1_len", n, 4);
    measure(n); check("allred1_len", n, 2);
    check("home_return", int'({phase, cur_dir}), 0);

    car = 4'b0010;
    wait_state(0, 1, "held_serve", n);
    measure(n); check("green1_max_len", n, 16);
    measure(n); measure(n);
    check("after_max_home", int'({phase, cur_dir}), 0);
    car = '0;
    repeat (80) @(negedge clock);

    pulse(4'b1100);
    wait_state(0, 2, "rr_first", n);
    check("rr_first_dir", int'(cur_dir), 2);
    wait_new_green(2, "rr_second", d); check("rr_second_dir", d, 3);
    wait_new_green(3, "rr_third", d);  check("rr_third_dir", d, 0);
    repeat (20) @(negedge clock);

    pulse(4'b0010);
    wait_state(1, 0, "pre_reset_yellow", n);
    #2 reset = 1'b1;
    #1;
    check("async_rst_green", int'(green), 1);
    check("async_rst_yellow", int'(yellow), 0);
    check("async_rst_phase", int'(phase), 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("pend_lost", int'({phase, cur_dir}), 0);

    tyel = 4'd0; tar = 4'd0;
    pulse(4'b0010);
    wait_state(1, 0, "zero_time", n);
    measure(n); check("yellow_zero_len", n, 2);
    measure(n); check("allred_zero_len", n, 2);
    check("zero_served", int'(cur_dir), 1);
    tyel = 4'd2; tar = 4'd1;
    repeat (40) @(negedge clock);

    for (int c = 0; c < 5000; c++) begin
      int b;
      @(negedge clock);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, ND - 1);
        car[b] = ~car[b];
      end
      if ($urandom_range(0, 149) == 0) begin
        tmin = 4'($urandom_range(0, 9));
        tmax = 4'($urandom_range(0, 15));
        tyel = 4'($urandom_range(0, 4));
        tar  = 4'($urandom_range(0, 3));
      end
    end
    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
